// File: rtl/memory_access.sv
// Memory-access stage: RV32I loads/stores over a req/gnt/rvalid data-memory port,
// with a registered result for writeback and an upstream stall while busy.
module memory_access #(
  parameter int XLEN     = 32,
  parameter int RD_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                E_valid_i,
  input  logic [XLEN-1:0]     E_valE_i,
  input  logic [XLEN-1:0]     E_rs2_data_i,
  input  logic                E_op_load_i,
  input  logic                E_op_store_i,
  input  logic [2:0]          E_funct3_i,
  input  logic [RD_WIDTH-1:0] E_rd_i,
  input  logic                E_wb_en_i,
  output logic                M_stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  output logic [3:0]          dmem_wstrb_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic                M_valid_o,
  output logic [XLEN-1:0]     M_valM_o,
  output logic [RD_WIDTH-1:0] M_rd_o,
  output logic                M_wb_en_o,
  output logic                M_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state;
  logic [2:0]            funct3_q;
  logic [1:0]            lo_q;
  logic [RD_WIDTH-1:0]   rd_q;
  logic                  wb_en_q;

  logic                  is_mem;
  logic                  misalign;
  logic [XLEN-1:0]       wdata_fmt;
  logic [3:0]            wstrb_fmt;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [XLEN-1:0]       load_fmt;

  assign M_stall_o = (state != IDLE);
  assign is_mem    = E_op_load_i | E_op_store_i;

  // Size comes from funct3[1:0]; the undefined 011 pattern behaves as a word.
  assign misalign = is_mem &&
                    (((E_funct3_i[1:0] == 2'b01) && E_valE_i[0]) ||
                     (E_funct3_i[1] && (E_valE_i[1:0] != 2'b00)));

  always_comb begin
    wdata_fmt = E_rs2_data_i;
    wstrb_fmt = 4'b1111;
    case (E_funct3_i[1:0])
      2'b00: begin
        wdata_fmt = {4{E_rs2_data_i[7:0]}};
        wstrb_fmt = 4'b0001 << E_valE_i[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{E_rs2_data_i[15:0]}};
        wstrb_fmt = E_valE_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking ones would make the result depend on statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      funct3_q     <= '0;
      lo_q         <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_wstrb_o <= '0;
      M_valid_o    <= 1'b0;
      M_valM_o     <= '0;
      M_rd_o       <= '0;
      M_wb_en_o    <= 1'b0;
      M_misalign_o <= 1'b0;
    end else begin
      M_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (E_valid_i) begin
            if (!is_mem || misalign) begin
              M_valid_o    <= 1'b1;
              M_valM_o     <= E_valE_i;
              M_rd_o       <= E_rd_i;
              M_wb_en_o    <= E_wb_en_i & ~is_mem;
              M_misalign_o <= is_mem;
            end else begin
              state        <= REQ;
              funct3_q     <= E_funct3_i;
              lo_q         <= E_valE_i[1:0];
              rd_q         <= E_rd_i;
              wb_en_q      <= E_wb_en_i;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= E_op_store_i;
              dmem_addr_o  <= {E_valE_i[XLEN-1:2], 2'b00};
              dmem_wdata_o <= E_op_store_i ? wdata_fmt : '0;
              dmem_wstrb_o <= E_op_store_i ? wstrb_fmt : 4'b0000;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state        <= IDLE;
              M_valid_o    <= 1'b1;
              M_valM_o     <= {dmem_addr_o[XLEN-1:2], lo_q};
              M_rd_o       <= rd_q;
              M_wb_en_o    <= 1'b0;
              M_misalign_o <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            state        <= IDLE;
            M_valid_o    <= 1'b1;
            M_valM_o     <= load_fmt;
            M_rd_o       <= rd_q;
            M_wb_en_o    <= wb_en_q;
            M_misalign_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU pass-through, stores, loads, misalignment
// and reset mid-transaction, all with hand-computed expectations.
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        E_valid_i;
  logic [31:0] E_valE_i;
  logic [31:0] E_rs2_data_i;
  logic        E_op_load_i;
  logic        E_op_store_i;
  logic [2:0]  E_funct3_i;
  logic [4:0]  E_rd_i;
  logic        E_wb_en_i;
  logic        M_stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        M_valid_o;
  logic [31:0] M_valM_o;
  logic [4:0]  M_rd_o;
  logic        M_wb_en_o;
  logic        M_misalign_o;

  int checks = 0;
  int errors = 0;

  memory_access #(.XLEN(32), .RD_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .E_valid_i(E_valid_i), .E_valE_i(E_valE_i), .E_rs2_data_i(E_rs2_data_i),
    .E_op_load_i(E_op_load_i), .E_op_store_i(E_op_store_i),
    .E_funct3_i(E_funct3_i), .E_rd_i(E_rd_i), .E_wb_en_i(E_wb_en_i),
    .M_stall_o(M_stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .M_valid_o(M_valid_o), .M_valM_o(M_valM_o), .M_rd_o(M_rd_o),
    .M_wb_en_o(M_wb_en_o), .M_misalign_o(M_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    E_valid_i    = 1'b0;
    E_op_load_i  = 1'b0;
    E_op_store_i = 1'b0;
  endtask

  task automatic issue(input logic load, input logic store, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wb);
    E_valid_i    = 1'b1;
    E_op_load_i  = load;
    E_op_store_i = store;
    E_funct3_i   = f3;
    E_valE_i     = addr;
    E_rs2_data_i = rs2;
    E_rd_i       = rd;
    E_wb_en_i    = wb;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    M_valid_o,    0);
    check({tag, "_valM"},     M_valM_o,     0);
    check({tag, "_rd"},       M_rd_o,       0);
    check({tag, "_wb_en"},    M_wb_en_o,    0);
    check({tag, "_misalign"}, M_misalign_o, 0);
    check({tag, "_req"},      dmem_req_o,   0);
    check({tag, "_we"},       dmem_we_o,    0);
    check({tag, "_addr"},     dmem_addr_o,  0);
    check({tag, "_wdata"},    dmem_wdata_o, 0);
    check({tag, "_wstrb"},    dmem_wstrb_o, 0);
    check({tag, "_stall"},    M_stall_o,    0);
  endtask

  initial begin
    rst_i         = 1'b1;
    E_valE_i      = '0;
    E_rs2_data_i  = '0;
    E_funct3_i    = '0;
    E_rd_i        = '0;
    E_wb_en_i     = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    idle_inputs();
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // Back-to-back ALU results
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    check("alu_stall0", M_stall_o, 0);
    tick();
    check("alu1_valid", M_valid_o, 1);
    check("alu1_valM",  M_valM_o,  32'h0000_1234);
    check("alu1_rd",    M_rd_o,    5);
    check("alu1_wb",    M_wb_en_o, 1);
    check("alu_stall1", M_stall_o, 0);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_5678, 32'h0, 5'd6, 1'b1);
    tick();
    check("alu2_valid", M_valid_o, 1);
    check("alu2_valM",  M_valM_o,  32'h0000_5678);
    check("alu2_rd",    M_rd_o,    6);
    check("alu_stall2", M_stall_o, 0);
    idle_inputs();
    tick();
    check("alu_pulse_end", M_valid_o, 0);
    check("alu_hold_valM", M_valM_o,  32'h0000_5678);

    // SB with two cycles of grant wait
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd9, 1'b0);
    tick();
    idle_inputs();
    check("sb_req",   dmem_req_o,   1);
    check("sb_we",    dmem_we_o,    1);
    check("sb_addr",  dmem_addr_o,  32'h0000_1000);
    check("sb_wdata", dmem_wdata_o, 32'hDDDD_DDDD);
    check("sb_wstrb", dmem_wstrb_o, 4'b1000);
    check("sb_stall", M_stall_o,    1);
    tick();
    check("sb_req_hold",   dmem_req_o,   1);
    check("sb_wdata_hold", dmem_wdata_o, 32'hDDDD_DDDD);
    check("sb_addr_hold",  dmem_addr_o,  32'h0000_1000);
    check("sb_valid_wait", M_valid_o,    0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("sb_done_valid", M_valid_o, 1);
    check("sb_done_wb",    M_wb_en_o, 0);
    check("sb_done_req",   dmem_req_o, 0);
    check("sb_done_stall", M_stall_o, 0);
    tick();
    check("sb_pulse_end", M_valid_o, 0);

    // LB then LBU, response three cycles after grant
    for (int pass = 0; pass < 2; pass++) begin
      issue(1'b1, 1'b0, (pass == 0) ? 3'b000 : 3'b100, 32'h0000_2002, 32'h0, 5'd7, 1'b1);
      tick();
      idle_inputs();
      check("lb_req",   dmem_req_o,   1);
      check("lb_we",    dmem_we_o,    0);
      check("lb_wstrb", dmem_wstrb_o, 0);
      check("lb_addr",  dmem_addr_o,  32'h0000_2000);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      check("lb_req_drop",  dmem_req_o, 0);
      check("lb_stall_w0",  M_stall_o,  1);
      dmem_rdata_i = 32'hFFFF_FFFF;
      tick();
      check("lb_stall_w1",  M_stall_o,  1);
      tick();
      check("lb_stall_w2",  M_stall_o,  1);
      check("lb_no_valid",  M_valid_o,  0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h0080_0000;
      tick();
      dmem_rvalid_i = 1'b0;
      check("lb_valid", M_valid_o, 1);
      check("lb_valM",  M_valM_o,  (pass == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      check("lb_rd",    M_rd_o,    7);
      check("lb_wb",    M_wb_en_o, 1);
      check("lb_stall_done", M_stall_o, 0);
    end

    // Misaligned LH: no request, flagged result
    issue(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 5'd3, 1'b1);
    tick();
    idle_inputs();
    check("lh_mis_req",   dmem_req_o,   0);
    check("lh_mis_valid", M_valid_o,    1);
    check("lh_mis_flag",  M_misalign_o, 1);
    check("lh_mis_wb",    M_wb_en_o,    0);
    check("lh_mis_valM",  M_valM_o,     32'h0000_3001);
    check("lh_mis_stall", M_stall_o,    0);

    // Aligned LW with immediate grant and response
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd4, 1'b1);
    tick();
    idle_inputs();
    check("lw_addr", dmem_addr_o, 32'h0000_3004);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_BABE;
    tick();
    dmem_rvalid_i = 1'b0;
    check("lw_valid", M_valid_o,    1);
    check("lw_valM",  M_valM_o,     32'hCAFE_BABE);
    check("lw_flag",  M_misalign_o, 0);
    check("lw_wb",    M_wb_en_o,    1);

    // Reset while waiting for a load response
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd8, 1'b1);
    tick();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("rst_wait_stall", M_stall_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i         = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1357_9BDF;
    tick();
    dmem_rvalid_i = 1'b0;
    check_all_zero("rst_mid");
    tick();
    check("rst_after_valid", M_valid_o, 0);

    // SH to upper half
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF, 5'd1, 1'b1);
    tick();
    idle_inputs();
    check("sh_addr",  dmem_addr_o,  32'h0000_0000);
    check("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    check("sh_wstrb", dmem_wstrb_o, 4'b1100);
    check("sh_we",    dmem_we_o,    1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("sh_valid", M_valid_o, 1);
    check("sh_wb",    M_wb_en_o, 0);
    check("sh_rd",    M_rd_o,    1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
